// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit bus writer: byte handshake in, two enable-strobed nibbles out.
// Optional power-on init sequence enabled by defining LCD_INIT_SEQ_EN.
module lcd_nibble_writer #(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int SETUP_CYCLES      = 2,
    parameter int PULSE_CYCLES      = 12,
    parameter int NIBBLE_GAP_CYCLES = 50,
    parameter int CMD_GAP_CYCLES    = 2000,
    parameter int LONG_GAP_CYCLES   = 82000,
    parameter int INIT_GAP1_CYCLES  = 205000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic [3:0] oLCD,
    output logic       oEnable,
    output logic       oRegisterSelect,
    output logic       oReadWrite
);
    localparam int CW = 20;

    // Counter is loaded with N-1 so each state lasts exactly N cycles.
    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] LD_NGAP  = CW'(NIBBLE_GAP_CYCLES - 1);
    localparam logic [CW-1:0] LD_CMD   = CW'(CMD_GAP_CYCLES - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(LONG_GAP_CYCLES - 1);
`ifdef LCD_INIT_SEQ_EN
    localparam logic [CW-1:0] LD_POWERUP = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_GAP1    = CW'(INIT_GAP1_CYCLES - 1);
`endif

    typedef enum logic [3:0] {
        S_POWERUP, S_INIT_SETUP, S_INIT_PULSE, S_INIT_GAP, S_IDLE,
        S_SETUP_H, S_PULSE_H, S_GAP_H, S_SETUP_L, S_PULSE_L, S_GAP_L
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      lo_nib_q;
    logic            long_gap_q;
    logic            ready_q;
    logic [3:0]      lcd_q;
    logic            en_q;
    logic            rs_q;
    logic            cnt_done;
`ifdef LCD_INIT_SEQ_EN
    logic [1:0]      init_idx_q;
`else
    logic            unused_init;
    assign unused_init = ^{POWERUP_CYCLES, INIT_GAP1_CYCLES};
`endif

    assign cnt_done = (cnt_q == '0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
`ifdef LCD_INIT_SEQ_EN
            state_q    <= S_POWERUP;
            cnt_q      <= LD_POWERUP;
            init_idx_q <= '0;
`else
            state_q    <= S_IDLE;
            cnt_q      <= '0;
`endif
            lo_nib_q   <= '0;
            long_gap_q <= 1'b0;
            ready_q    <= 1'b0;
            lcd_q      <= '0;
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
        end else begin
            if (!cnt_done)
                cnt_q <= cnt_q - CW'(1);
            case (state_q)
`ifdef LCD_INIT_SEQ_EN
                S_POWERUP: if (cnt_done) begin
                    state_q <= S_INIT_SETUP;
                    cnt_q   <= LD_SETUP;
                    lcd_q   <= 4'h3;
                    rs_q    <= 1'b0;
                end
                S_INIT_SETUP: if (cnt_done) begin
                    state_q <= S_INIT_PULSE;
                    cnt_q   <= LD_PULSE;
                    en_q    <= 1'b1;
                end
                S_INIT_PULSE: if (cnt_done) begin
                    state_q <= S_INIT_GAP;
                    cnt_q   <= (init_idx_q == 2'd0) ? LD_GAP1 : LD_CMD;
                    en_q    <= 1'b0;
                end
                S_INIT_GAP: if (cnt_done) begin
                    if (init_idx_q == 2'd3) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state_q    <= S_INIT_SETUP;
                        cnt_q      <= LD_SETUP;
                        init_idx_q <= init_idx_q + 2'd1;
                        // Last of the four init nibbles switches to 4-bit mode.
                        lcd_q      <= (init_idx_q == 2'd2) ? 4'h2 : 4'h3;
                    end
                end
`endif
                S_IDLE: begin
                    if (ready_q && iValid) begin
                        ready_q    <= 1'b0;
                        state_q    <= S_SETUP_H;
                        cnt_q      <= LD_SETUP;
                        lcd_q      <= iData[7:4];
                        lo_nib_q   <= iData[3:0];
                        rs_q       <= iRS;
                        long_gap_q <= !iRS && (iData == 8'h01 || iData == 8'h02 ||
                                               iData == 8'h03);
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_SETUP_H: if (cnt_done) begin
                    state_q <= S_PULSE_H;
                    cnt_q   <= LD_PULSE;
                    en_q    <= 1'b1;
                end
                S_PULSE_H: if (cnt_done) begin
                    state_q <= S_GAP_H;
                    cnt_q   <= LD_NGAP;
                    en_q    <= 1'b0;
                end
                S_GAP_H: if (cnt_done) begin
                    state_q <= S_SETUP_L;
                    cnt_q   <= LD_SETUP;
                    lcd_q   <= lo_nib_q;
                end
                S_SETUP_L: if (cnt_done) begin
                    state_q <= S_PULSE_L;
                    cnt_q   <= LD_PULSE;
                    en_q    <= 1'b1;
                end
                S_PULSE_L: if (cnt_done) begin
                    state_q <= S_GAP_L;
                    cnt_q   <= long_gap_q ? LD_LONG : LD_CMD;
                    en_q    <= 1'b0;
                end
                S_GAP_L: if (cnt_done) begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    en_q    <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign oReady          = ready_q;
    assign oLCD            = lcd_q;
    assign oEnable         = en_q;
    assign oRegisterSelect = rs_q;
    assign oReadWrite      = 1'b0;
endmodule
